// File: rtl/mips_hazard_pkg.sv
// rtl/mips_hazard_pkg.sv - shared forward-select codes and scoreboard slot type for the ID-stage hazard unit
package mips_hazard_pkg;

  localparam int HZ_REG_AW = 5;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_MEM     = 2'b01;
  localparam logic [1:0] FWD_EX      = 2'b10;

  typedef struct packed {
    logic                 valid;
    logic                 regwrite;
    logic                 memread;
    logic [HZ_REG_AW-1:0] wreg;
  } hz_slot_t;

endpackage

// File: rtl/hazard_src_check.sv
// rtl/hazard_src_check.sv - per-source dependency check against the EX/MEM scoreboard slots
module hazard_src_check
  import mips_hazard_pkg::*;
#(
  parameter int REG_AW   = HZ_REG_AW,
  parameter int ZERO_REG = 0
) (
  input  logic [REG_AW-1:0] src,
  input  logic              uses,
  input  hz_slot_t          ex_slot,
  input  hz_slot_t          mem_slot,
  input  logic              is_branch,
  output logic [1:0]        fwd_sel,
  output logic              stall_req
);

  logic checked;
  logic ex_hit;
  logic mem_hit;

  assign checked = uses && (src != REG_AW'(ZERO_REG));
  assign ex_hit  = checked && ex_slot.valid && ex_slot.regwrite &&
                   (ex_slot.wreg != REG_AW'(ZERO_REG)) && (ex_slot.wreg == src);
  assign mem_hit = checked && mem_slot.valid && mem_slot.regwrite &&
                   (mem_slot.wreg != REG_AW'(ZERO_REG)) && (mem_slot.wreg == src);

  always_comb begin
    fwd_sel   = FWD_REGFILE;
    stall_req = 1'b0;
    if (is_branch) begin
      // The youngest producer wins; a load result is not available in time for the ID compare.
      if (ex_hit) begin
        if (ex_slot.memread) stall_req = 1'b1;
        else                 fwd_sel   = FWD_EX;
      end else if (mem_hit) begin
        if (mem_slot.memread) stall_req = 1'b1;
        else                  fwd_sel   = FWD_MEM;
      end
    end else begin
      stall_req = ex_hit && ex_slot.memread;
    end
  end

endmodule

// File: rtl/branch_hazard_unit.sv
// rtl/branch_hazard_unit.sv - ID-stage branch forwarding and stall control; BRANCH_HAZARD_STATS_EN adds counters
module branch_hazard_unit
  import mips_hazard_pkg::*;
#(
  parameter int REG_AW   = HZ_REG_AW,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic              id_is_branch,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic [REG_AW-1:0] id_wreg,
  input  logic              flush,
  output logic [1:0]        forwardrsd,
  output logic [1:0]        forwardrtd,
  output logic              stall
`ifdef BRANCH_HAZARD_STATS_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       branch_fwd_cnt,
  output logic [15:0]       load_branch_stalls
`endif
);

  hz_slot_t   ex_slot;
  hz_slot_t   mem_slot;
  logic       is_branch;
  logic [1:0] rs_sel;
  logic [1:0] rt_sel;
  logic       rs_stall;
  logic       rt_stall;

  assign is_branch = id_valid && id_is_branch && !flush;

  hazard_src_check #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_rs_check (
    .src(id_rs), .uses(id_uses_rs), .ex_slot(ex_slot), .mem_slot(mem_slot),
    .is_branch(is_branch), .fwd_sel(rs_sel), .stall_req(rs_stall)
  );

  hazard_src_check #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_rt_check (
    .src(id_rt), .uses(id_uses_rt), .ex_slot(ex_slot), .mem_slot(mem_slot),
    .is_branch(is_branch), .fwd_sel(rt_sel), .stall_req(rt_stall)
  );

  // A flushed or empty ID slot never stalls; a stalled branch must not consume a forward.
  assign stall      = id_valid && !flush && (rs_stall || rt_stall);
  assign forwardrsd = stall ? FWD_REGFILE : rs_sel;
  assign forwardrtd = stall ? FWD_REGFILE : rt_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_slot  <= '0;
      mem_slot <= '0;
    end else begin
      mem_slot <= ex_slot;
      if (stall || flush || !id_valid) begin
        ex_slot <= '0;
      end else begin
        ex_slot.valid    <= 1'b1;
        ex_slot.regwrite <= id_regwrite;
        ex_slot.memread  <= id_memread;
        ex_slot.wreg     <= id_wreg;
      end
    end
  end

`ifdef BRANCH_HAZARD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles       <= '0;
      branch_fwd_cnt     <= '0;
      load_branch_stalls <= '0;
    end else begin
      if (stall) stall_cycles <= stall_cycles + 32'd1;
      if (is_branch && ((forwardrsd != FWD_REGFILE) || (forwardrtd != FWD_REGFILE)))
        branch_fwd_cnt <= branch_fwd_cnt + 32'd1;
      if (stall && is_branch) load_branch_stalls <= load_branch_stalls + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_hazard_unit.sv
// tb/tb_branch_hazard_unit.sv - directed and randomized checks of branch_hazard_unit against a pipeline model
module tb_branch_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_is_branch, id_uses_rs, id_uses_rt;
  logic       id_regwrite, id_memread, flush;
  logic [4:0] id_rs, id_rt, id_wreg;
  logic [1:0] forwardrsd, forwardrtd;
  logic       stall;
`ifdef BRANCH_HAZARD_STATS_EN
  logic [31:0] stall_cycles, branch_fwd_cnt;
  logic [15:0] load_branch_stalls;
`endif

  int compared   = 0;
  int mismatched = 0;
  int exp_stall_cycles = 0;

  typedef struct {
    bit       live;
    bit       load;
    bit [4:0] wreg;
  } ent_t;
  ent_t pipe[$];  // pipe[0] = instruction now in EX, pipe[1] = in MEM

  branch_hazard_unit dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_is_branch(id_is_branch),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_wreg(id_wreg),
    .flush(flush), .forwardrsd(forwardrsd), .forwardrtd(forwardrtd), .stall(stall)
`ifdef BRANCH_HAZARD_STATS_EN
    , .stall_cycles(stall_cycles), .branch_fwd_cnt(branch_fwd_cnt),
    .load_branch_stalls(load_branch_stalls)
`endif
  );

  always #5 clk = ~clk;

  task automatic clear_pipe();
    ent_t b;
    b.live = 0; b.load = 0; b.wreg = 0;
    pipe.delete();
    pipe.push_back(b);
    pipe.push_back(b);
  endtask

  task automatic set_id(input bit v, input bit br, input bit [4:0] rs, input bit [4:0] rt,
                        input bit urs, input bit urt, input bit rw, input bit mr,
                        input bit [4:0] wr, input bit fl);
    id_valid = v; id_is_branch = br; id_rs = rs; id_rt = rt;
    id_uses_rs = urs; id_uses_rt = urt; id_regwrite = rw; id_memread = mr;
    id_wreg = wr; flush = fl;
  endtask

  task automatic nop();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Age of the youngest in-flight writer of r (1 = EX, 2 = MEM, 0 = none) and whether it is a load.
  task automatic producer(input bit [4:0] r, input bit uses, output int age, output bit ld);
    age = 0; ld = 0;
    if (uses && r != 0) begin
      for (int a = 0; a < pipe.size(); a++) begin
        if (age == 0 && pipe[a].live && pipe[a].wreg == r) begin
          age = a + 1;
          ld  = pipe[a].load;
        end
      end
    end
  endtask

  task automatic model(output bit [1:0] ers, output bit [1:0] ert, output bit est);
    int a_rs, a_rt;
    bit l_rs, l_rt, br;
    producer(id_rs, id_uses_rs, a_rs, l_rs);
    producer(id_rt, id_uses_rt, a_rt, l_rt);
    br  = id_valid && id_is_branch && !flush;
    ers = 2'b00; ert = 2'b00; est = 0;
    if (br) begin
      if (a_rs != 0 && l_rs) est = 1;
      if (a_rt != 0 && l_rt) est = 1;
      if (a_rs != 0 && !l_rs) ers = (a_rs == 1) ? 2'b10 : 2'b01;
      if (a_rt != 0 && !l_rt) ert = (a_rt == 1) ? 2'b10 : 2'b01;
    end else if (id_valid && !flush) begin
      est = (a_rs == 1 && l_rs) || (a_rt == 1 && l_rt);
    end
    if (est) begin ers = 2'b00; ert = 2'b00; end
  endtask

  task automatic tick();
    bit [1:0] ers, ert;
    bit est;
    ent_t e;
    model(ers, ert, est);
    @(posedge clk);
    if (est) exp_stall_cycles++;
    e.live = !(est || flush || !id_valid) && id_regwrite && id_wreg != 0;
    e.load = id_memread;
    e.wreg = id_wreg;
    pipe.push_front(e);
    void'(pipe.pop_back());
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    set_id(1, 1, 5'd3, 5'd4, 1, 1, 1, 1, 5'd3, 0);
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if (stall !== 1'b0 || forwardrsd !== 2'b00 || forwardrtd !== 2'b00) begin
      mismatched++;
      $display("FAIL reset_outputs: stall=%b rsd=%b rtd=%b required 0/00/00", stall, forwardrsd, forwardrtd);
    end
    rst_n = 1;
    clear_pipe();
    exp_stall_cycles = 0;
    nop(); tick(); tick();
  endtask

  task automatic test_ex_fwd();
    set_id(1, 0, 5'd1, 5'd2, 1, 1, 1, 0, 5'd3, 0); tick();
    set_id(1, 1, 5'd3, 5'd4, 1, 1, 0, 0, 5'd0, 0);
    @(negedge clk);
    compared++;
    if (forwardrsd !== 2'b10 || forwardrtd !== 2'b00 || stall !== 1'b0) begin
      mismatched++;
      $display("FAIL ex_fwd: rsd=%b rtd=%b stall=%b required 10/00/0", forwardrsd, forwardrtd, stall);
    end
    tick(); nop(); tick(); tick();
  endtask

  task automatic test_mem_fwd();
    set_id(1, 0, 5'd1, 5'd2, 1, 1, 1, 0, 5'd5, 0); tick();
    nop(); tick();
    set_id(1, 1, 5'd6, 5'd5, 1, 1, 0, 0, 5'd0, 0);
    @(negedge clk);
    compared++;
    if (forwardrsd !== 2'b00 || forwardrtd !== 2'b01 || stall !== 1'b0) begin
      mismatched++;
      $display("FAIL mem_fwd: rsd=%b rtd=%b stall=%b required 00/01/0", forwardrsd, forwardrtd, stall);
    end
    tick(); nop(); tick(); tick();
  endtask

  task automatic test_load_use();
    bit [2:0] exp_st;
`ifdef BRANCH_HAZARD_STATS_EN
    int sc0;
    sc0 = stall_cycles;
`endif
    set_id(1, 0, 5'd1, 5'd0, 1, 0, 1, 1, 5'd7, 0); tick();
    set_id(1, 1, 5'd7, 5'd0, 1, 1, 0, 0, 5'd0, 0);
    exp_st = 3'b011;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      compared++;
      if (stall !== exp_st[c] || forwardrsd !== 2'b00 || forwardrtd !== 2'b00) begin
        mismatched++;
        $display("FAIL load_branch_c%0d: stall=%b rsd=%b rtd=%b required %b/00/00", c, stall, forwardrsd, forwardrtd, exp_st[c]);
      end
      tick();
    end
`ifdef BRANCH_HAZARD_STATS_EN
    compared++;
    if (stall_cycles - sc0 !== 2) begin
      mismatched++;
      $display("FAIL stats_two_stalls: delta=%0d required 2", stall_cycles - sc0);
    end
`endif
    nop(); tick(); tick();
    set_id(1, 0, 5'd1, 5'd0, 1, 0, 1, 1, 5'd7, 0); tick();
    set_id(1, 0, 5'd7, 5'd1, 1, 1, 1, 0, 5'd8, 0);
    exp_st = 3'b001;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      compared++;
      if (stall !== exp_st[c]) begin
        mismatched++;
        $display("FAIL load_use_c%0d: stall=%b required %b", c, stall, exp_st[c]);
      end
      tick();
    end
    nop(); tick(); tick();
  endtask

  task automatic test_priority_zero();
    set_id(1, 0, 5'd1, 5'd0, 1, 0, 1, 0, 5'd2, 0); tick();
    set_id(1, 0, 5'd1, 5'd4, 1, 1, 1, 0, 5'd2, 0); tick();
    set_id(1, 1, 5'd2, 5'd2, 1, 1, 0, 0, 5'd0, 0);
    @(negedge clk);
    compared++;
    if (forwardrsd !== 2'b10 || forwardrtd !== 2'b10 || stall !== 1'b0) begin
      mismatched++;
      $display("FAIL ex_priority: rsd=%b rtd=%b stall=%b required 10/10/0", forwardrsd, forwardrtd, stall);
    end
    tick(); nop(); tick(); tick();
    set_id(1, 0, 5'd1, 5'd0, 1, 0, 1, 1, 5'd0, 0); tick();
    set_id(1, 1, 5'd0, 5'd1, 1, 1, 0, 0, 5'd0, 0);
    @(negedge clk);
    compared++;
    if (forwardrsd !== 2'b00 || forwardrtd !== 2'b00 || stall !== 1'b0) begin
      mismatched++;
      $display("FAIL zero_reg: rsd=%b rtd=%b stall=%b required 00/00/0", forwardrsd, forwardrtd, stall);
    end
    tick(); nop(); tick(); tick();
  endtask

  task automatic test_flush();
    set_id(1, 0, 5'd1, 5'd0, 1, 0, 1, 1, 5'd9, 0); tick();
    // Wrong-path slot carries load-like decode so a missing bubble would show up as an extra stall.
    set_id(1, 1, 5'd9, 5'd1, 1, 1, 1, 1, 5'd9, 1);
    @(negedge clk);
    compared++;
    if (stall !== 1'b0 || forwardrsd !== 2'b00 || forwardrtd !== 2'b00) begin
      mismatched++;
      $display("FAIL flush_wins: stall=%b rsd=%b rtd=%b required 0/00/00", stall, forwardrsd, forwardrtd);
    end
    tick();
    set_id(1, 1, 5'd9, 5'd1, 1, 1, 0, 0, 5'd0, 0);
    @(negedge clk);
    compared++;
    if (stall !== 1'b1) begin
      mismatched++;
      $display("FAIL flush_mem_load: stall=%b required 1", stall);
    end
    tick();
    @(negedge clk);
    compared++;
    if (stall !== 1'b0 || forwardrsd !== 2'b00) begin
      mismatched++;
      $display("FAIL flush_bubble: stall=%b rsd=%b required 0/00", stall, forwardrsd);
    end
    tick(); nop(); tick(); tick();
  endtask

  task automatic test_reset_mid_stall();
    set_id(1, 0, 5'd1, 5'd0, 1, 0, 1, 1, 5'd7, 0); tick();
    set_id(1, 1, 5'd7, 5'd0, 1, 1, 0, 0, 5'd0, 0);
    #2;
    compared++;
    if (stall !== 1'b1) begin
      mismatched++;
      $display("FAIL pre_reset_stall: stall=%b required 1", stall);
    end
    rst_n = 0;
    #1;
    compared++;
    if (stall !== 1'b0 || forwardrsd !== 2'b00 || forwardrtd !== 2'b00) begin
      mismatched++;
      $display("FAIL async_reset_stall: stall=%b rsd=%b rtd=%b required 0/00/00", stall, forwardrsd, forwardrtd);
    end
`ifdef BRANCH_HAZARD_STATS_EN
    compared++;
    if (stall_cycles !== 32'd0) begin
      mismatched++;
      $display("FAIL stats_reset: stall_cycles=%0d required 0", stall_cycles);
    end
`endif
    @(posedge clk); #1;
    rst_n = 1;
    clear_pipe();
    exp_stall_cycles = 0;
    @(negedge clk);
    compared++;
    if (stall !== 1'b0 || forwardrsd !== 2'b00) begin
      mismatched++;
      $display("FAIL post_reset_branch: stall=%b rsd=%b required 0/00", stall, forwardrsd);
    end
    tick(); nop(); tick(); tick();
  endtask

  task automatic test_random();
    bit [1:0] ers, ert;
    bit est;
    for (int i = 0; i < 400; i++) begin
      set_id($urandom_range(0, 7) != 0, $urandom_range(0, 1), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 5'($urandom_range(0, 3)),
             $urandom_range(0, 15) == 0);
      @(negedge clk);
      model(ers, ert, est);
      compared++;
      if (stall !== est || forwardrsd !== ers || forwardrtd !== ert) begin
        mismatched++;
        $display("FAIL random_%0d: stall=%b rsd=%b rtd=%b required %b/%b/%b", i, stall, forwardrsd, forwardrtd, est, ers, ert);
      end
      tick();
    end
`ifdef BRANCH_HAZARD_STATS_EN
    compared++;
    if (stall_cycles !== 32'(exp_stall_cycles)) begin
      mismatched++;
      $display("FAIL stats_random: stall_cycles=%0d required %0d", stall_cycles, exp_stall_cycles);
    end
`endif
  endtask

  initial begin
    clear_pipe();
    nop();
    test_reset();
    test_ex_fwd();
    test_mem_fwd();
    test_load_use();
    test_priority_zero();
    test_flush();
    test_reset_mid_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
